// File: rtl/wb_commit_checker.sv
// Commit-trace checker: compacts per-lane writeback commits into an in-order
// queue and compares each entry against a reference trace stream. It stops on
// the first mismatch and holds the failing pair, or flags completion when the
// reference reaches END_PC.
//
// state | meaning
// ------+-------------------------------------------------------------
// SYNC  | dropping reference entries until BEGIN_PC is presented
// RUN   | popping queue entries and comparing them with the reference
// DONE  | END_PC consumed; terminal until reset
// ERR   | mismatch or queue overflow; terminal until reset
module wb_commit_checker #(
   parameter int          LANES     = 2,
   parameter int          DEPTH     = 8,
   parameter bit          SYNC_EN   = 1'b0,
   parameter logic [31:0] BEGIN_PC  = 32'hbfc00bd4,
   parameter logic [31:0] END_PC    = 32'hbfc00100,
   parameter logic [31:0] SKIP_BASE = 32'hbfc00380,
   parameter logic [31:0] SKIP_MASK = 32'hfffffff8,
   localparam int         LW        = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                trace_en,
   input  logic [LANES-1:0]    wb_en,
   input  logic [5*LANES-1:0]  wb_rd,
   input  logic [32*LANES-1:0] wb_wdata,
   input  logic [32*LANES-1:0] wb_pc,
   output logic                commit_stall,
   input  logic                ref_valid,
   input  logic [31:0]         ref_pc,
   input  logic [4:0]          ref_wnum,
   input  logic [31:0]         ref_wdata,
   output logic                ref_ready,
   output logic                done,
   output logic                err,
   output logic                overflow,
   output logic [LW-1:0]       err_lane,
   output logic [31:0]         err_pc,
   output logic [4:0]          err_wnum,
   output logic [31:0]         err_wdata,
   output logic [31:0]         err_ref_pc,
   output logic [4:0]          err_ref_wnum,
   output logic [31:0]         err_ref_wdata,
   output logic [31:0]         check_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_SYNC = 2'd1,
      ST_DONE = 2'd2,
      ST_ERR  = 2'd3
   } state_t;

   localparam state_t ST_START = SYNC_EN ? ST_SYNC : ST_RUN;

   state_t state_q, state_d;

   // commit queue storage; validity is tracked only by the pointers and count
   logic [31:0]   q_pc    [DEPTH];
   logic [4:0]    q_rd    [DEPTH];
   logic [31:0]   q_wdata [DEPTH];
   logic [LW-1:0] q_lane  [DEPTH];

   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;

   logic [AW-1:0] slot_idx [LANES];
   logic [CW-1:0] push_cnt;
   logic [CW-1:0] free_slots;

   logic          accepting;
   logic          push_over;
   logic          push_ok;
   logic          pop;
   logic          pop_end;
   logic          pop_skip;
   logic          pop_mismatch;
   logic          sync_drop;
   logic          sync_hit;

   logic [31:0]   head_pc;
   logic [4:0]    head_rd;
   logic [31:0]   head_wdata;
   logic [LW-1:0] head_lane;

   // Compaction: an enabled lane lands at wr_ptr plus the number of enabled lanes below it
   always_comb begin
      logic [AW-1:0] off;
      off = '0;
      for (int i = 0; i < LANES; i++) begin
         slot_idx[i] = wr_ptr_q + off;
         if (wb_en[i]) begin
            off = off + AW'(1);
         end
      end
      push_cnt = CW'(off);
   end

   // Queue head and handshake decode, all from registered occupancy and state
   always_comb begin
      head_pc      = q_pc[rd_ptr_q];
      head_rd      = q_rd[rd_ptr_q];
      head_wdata   = q_wdata[rd_ptr_q];
      head_lane    = q_lane[rd_ptr_q];

      free_slots   = CW'(DEPTH) - count_q;
      accepting    = (state_q == ST_SYNC) || (state_q == ST_RUN);
      push_over    = accepting && (push_cnt > free_slots);
      push_ok      = accepting && !push_over && (push_cnt != '0);
      commit_stall = accepting && (free_slots < CW'(LANES));

      pop          = (state_q == ST_RUN) && (count_q != '0) && ref_valid;
      sync_drop    = (state_q == ST_SYNC) && ref_valid && (ref_pc != BEGIN_PC);
      sync_hit     = (state_q == ST_SYNC) && ref_valid && (ref_pc == BEGIN_PC);
      ref_ready    = pop || sync_drop;

      pop_end      = pop && (ref_pc == END_PC);
      pop_skip     = pop && !pop_end &&
                     (!trace_en || ((head_pc & SKIP_MASK) == SKIP_BASE));
      pop_mismatch = pop && !pop_end && !pop_skip &&
                     ((head_pc != ref_pc) || (head_rd != ref_wnum) ||
                      (head_wdata != ref_wdata));
   end

   // Next-state decode; an overflow wins over whatever the pop decided
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_SYNC: if (sync_hit) state_d = ST_RUN;
         ST_RUN: begin
            if (pop_end) begin
               state_d = ST_DONE;
            end else if (pop_mismatch) begin
               state_d = ST_ERR;
            end
         end
         default: state_d = state_q;
      endcase
      if (push_over) begin
         state_d = ST_ERR;
      end
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_START;
      end else begin
         state_q <= state_d;
      end
   end

   // Pointers and occupancy; count moves by the net of pushes and the pop
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + push_cnt[AW-1:0];
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         count_q <= count_q + (push_ok ? push_cnt : CW'(0)) - (pop ? CW'(1) : CW'(0));
      end
   end

   // Queue storage writes; no reset needed since empty slots are never read as valid
   always_ff @(posedge clk) begin
      if (push_ok) begin
         for (int i = 0; i < LANES; i++) begin
            if (wb_en[i]) begin
               q_pc[slot_idx[i]]    <= wb_pc[i*32 +: 32];
               q_rd[slot_idx[i]]    <= wb_rd[i*5 +: 5];
               q_wdata[slot_idx[i]] <= wb_wdata[i*32 +: 32];
               q_lane[slot_idx[i]]  <= LW'(i);
            end
         end
      end
   end

   // Sticky status, error record and saturating consumed-entry counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         done          <= 1'b0;
         err           <= 1'b0;
         overflow      <= 1'b0;
         err_lane      <= '0;
         err_pc        <= '0;
         err_wnum      <= '0;
         err_wdata     <= '0;
         err_ref_pc    <= '0;
         err_ref_wnum  <= '0;
         err_ref_wdata <= '0;
         check_count   <= '0;
      end else begin
         if (push_over) begin
            overflow <= 1'b1;
            err      <= 1'b1;
         end
         if (pop_end && !push_over) begin
            done <= 1'b1;
         end
         if (pop_mismatch) begin
            err           <= 1'b1;
            err_lane      <= head_lane;
            err_pc        <= head_pc;
            err_wnum      <= head_rd;
            err_wdata     <= head_wdata;
            err_ref_pc    <= ref_pc;
            err_ref_wnum  <= ref_wnum;
            err_ref_wdata <= ref_wdata;
         end
         if (pop && !pop_end && (check_count != 32'hffffffff)) begin
            check_count <= check_count + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_wb_commit_checker.sv
// Directed bench for wb_commit_checker: a vector table for the single-cycle
// behaviour plus hand sequences for overflow, end/reset and sync.
module tb_wb_commit_checker;

   localparam logic [31:0] END_PC = 32'hbfc00100;

   logic        clk = 1'b0;
   logic        reset, reset_s, trace_en;
   logic [1:0]  wb_en;
   logic [9:0]  wb_rd;
   logic [63:0] wb_wdata, wb_pc;
   logic        ref_valid;
   logic [31:0] ref_pc, ref_wdata;
   logic [4:0]  ref_wnum;

   logic        commit_stall, ref_ready, done, err, overflow;
   logic [0:0]  err_lane;
   logic [31:0] err_pc, err_wdata, err_ref_pc, err_ref_wdata, check_count;
   logic [4:0]  err_wnum, err_ref_wnum;

   logic        s_commit_stall, s_ref_ready, s_done, s_err, s_overflow;
   logic [0:0]  s_err_lane;
   logic [31:0] s_err_pc, s_err_wdata, s_err_ref_pc, s_err_ref_wdata, s_check_count;
   logic [4:0]  s_err_wnum, s_err_ref_wnum;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   wb_commit_checker #(.LANES(2), .DEPTH(8), .SYNC_EN(1'b0)) dut (
      .clk(clk), .reset(reset), .trace_en(trace_en),
      .wb_en(wb_en), .wb_rd(wb_rd), .wb_wdata(wb_wdata), .wb_pc(wb_pc),
      .commit_stall(commit_stall), .ref_valid(ref_valid), .ref_pc(ref_pc),
      .ref_wnum(ref_wnum), .ref_wdata(ref_wdata), .ref_ready(ref_ready),
      .done(done), .err(err), .overflow(overflow), .err_lane(err_lane),
      .err_pc(err_pc), .err_wnum(err_wnum), .err_wdata(err_wdata),
      .err_ref_pc(err_ref_pc), .err_ref_wnum(err_ref_wnum),
      .err_ref_wdata(err_ref_wdata), .check_count(check_count)
   );

   wb_commit_checker #(.LANES(2), .DEPTH(8), .SYNC_EN(1'b1)) dut_s (
      .clk(clk), .reset(reset_s), .trace_en(trace_en),
      .wb_en(wb_en), .wb_rd(wb_rd), .wb_wdata(wb_wdata), .wb_pc(wb_pc),
      .commit_stall(s_commit_stall), .ref_valid(ref_valid), .ref_pc(ref_pc),
      .ref_wnum(ref_wnum), .ref_wdata(ref_wdata), .ref_ready(s_ref_ready),
      .done(s_done), .err(s_err), .overflow(s_overflow), .err_lane(s_err_lane),
      .err_pc(s_err_pc), .err_wnum(s_err_wnum), .err_wdata(s_err_wdata),
      .err_ref_pc(s_err_ref_pc), .err_ref_wnum(s_err_ref_wnum),
      .err_ref_wdata(s_err_ref_wdata), .check_count(s_check_count)
   );

   typedef struct {
      logic [1:0]  en;
      logic [31:0] pc0;
      logic [4:0]  rd0;
      logic [31:0] d0;
      logic [31:0] pc1;
      logic [4:0]  rd1;
      logic [31:0] d1;
      logic        te;
      logic        rv;
      logic [31:0] rpc;
      logic [4:0]  rwn;
      logic [31:0] rwd;
      logic        x_ready;
      logic        x_stall;
      logic        x_err;
      logic        x_done;
      logic [31:0] x_cc;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [1:0] en,
                        input logic [31:0] pc0, input logic [4:0] rd0, input logic [31:0] d0,
                        input logic [31:0] pc1, input logic [4:0] rd1, input logic [31:0] d1,
                        input logic rv, input logic [31:0] rpc, input logic [4:0] rwn,
                        input logic [31:0] rwd);
      wb_en     = en;
      wb_pc     = {pc1, pc0};
      wb_rd     = {rd1, rd0};
      wb_wdata  = {d1, d0};
      ref_valid = rv;
      ref_pc    = rpc;
      ref_wnum  = rwn;
      ref_wdata = rwd;
   endtask

   task automatic add_vec(input logic [1:0] en,
                          input logic [31:0] pc0, input logic [4:0] rd0, input logic [31:0] d0,
                          input logic [31:0] pc1, input logic [4:0] rd1, input logic [31:0] d1,
                          input logic te, input logic rv, input logic [31:0] rpc,
                          input logic [4:0] rwn, input logic [31:0] rwd,
                          input logic xr, input logic xs, input logic xe, input logic xd,
                          input logic [31:0] xcc);
      vec_t v;
      v.en = en; v.pc0 = pc0; v.rd0 = rd0; v.d0 = d0;
      v.pc1 = pc1; v.rd1 = rd1; v.d1 = d1;
      v.te = te; v.rv = rv; v.rpc = rpc; v.rwn = rwn; v.rwd = rwd;
      v.x_ready = xr; v.x_stall = xs; v.x_err = xe; v.x_done = xd; v.x_cc = xcc;
      vecs.push_back(v);
   endtask

   task automatic idle();
      drive(2'b00, 0, 0, 0, 0, 0, 0, 1'b0, 0, 0, 0);
   endtask

   // Async reset pulse placed mid-cycle, away from any clock edge
   task automatic pulse_reset();
      @(negedge clk);
      idle();
      #2 reset = 1'b1;
      #1;
      check("reset_async_err", err, 1'b0);
      check("reset_async_cc", check_count, 32'd0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [1:0] ov_en [5];
      logic       ov_stall [5];

      reset    = 1'b1;
      reset_s  = 1'b1;
      trace_en = 1'b1;
      idle();

      // Dual push, in-order match
      add_vec(2'b11, 32'hbfc00000, 5'd1, 32'h1, 32'hbfc00004, 5'd2, 32'h2, 1, 1, 32'hbfc00000, 5'd1, 32'h1, 0, 0, 0, 0, 0);
      add_vec(2'b00, 0, 0, 0, 0, 0, 0, 1, 1, 32'hbfc00000, 5'd1, 32'h1, 1, 0, 0, 0, 1);
      add_vec(2'b00, 0, 0, 0, 0, 0, 0, 1, 1, 32'hbfc00004, 5'd2, 32'h2, 1, 0, 0, 0, 2);
      add_vec(2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2);
      // Compaction: lane 1 alone, then lane 0 alone with an overlapping pop
      add_vec(2'b10, 0, 0, 0, 32'hbfc00010, 5'd3, 32'h33, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2);
      add_vec(2'b01, 32'hbfc00014, 5'd4, 32'h44, 0, 0, 0, 1, 1, 32'hbfc00010, 5'd3, 32'h33, 1, 0, 0, 0, 3);
      add_vec(2'b00, 0, 0, 0, 0, 0, 0, 1, 1, 32'hbfc00014, 5'd4, 32'h44, 1, 0, 0, 0, 4);
      // Skip window: mismatching wdata is consumed silently
      add_vec(2'b01, 32'hbfc00384, 5'd5, 32'h55, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4);
      add_vec(2'b00, 0, 0, 0, 0, 0, 0, 1, 1, 32'hbfc00384, 5'd5, 32'hdead, 1, 0, 0, 0, 5);
      // trace_en low: mismatch consumed silently
      add_vec(2'b01, 32'hbfc00020, 5'd6, 32'h66, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5);
      add_vec(2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 32'hbfc00020, 5'd6, 32'h77, 1, 0, 0, 0, 6);
      // Compaction with corrupted second reference wdata
      add_vec(2'b10, 0, 0, 0, 32'hbfc00030, 5'd7, 32'h70, 1, 0, 0, 0, 0, 0, 0, 0, 0, 6);
      add_vec(2'b01, 32'hbfc00034, 5'd8, 32'h80, 0, 0, 0, 1, 1, 32'hbfc00030, 5'd7, 32'h70, 1, 0, 0, 0, 7);
      add_vec(2'b00, 0, 0, 0, 0, 0, 0, 1, 1, 32'hbfc00034, 5'd8, 32'h81, 1, 0, 1, 0, 8);
      // ERR: no handshake, no stall, pushes ignored
      add_vec(2'b11, 32'h1, 5'd1, 32'h1, 32'h2, 5'd2, 32'h2, 1, 1, 32'hbfc00034, 5'd8, 32'h81, 0, 0, 1, 0, 8);

      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst_stall", commit_stall, 1'b0);
      check("rst_ready", ref_ready, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_overflow", overflow, 1'b0);
      check("rst_cc", check_count, 32'd0);
      check("rst_err_pc", err_pc, 32'd0);

      foreach (vecs[k]) begin
         @(negedge clk);
         drive(vecs[k].en, vecs[k].pc0, vecs[k].rd0, vecs[k].d0, vecs[k].pc1, vecs[k].rd1,
               vecs[k].d1, vecs[k].rv, vecs[k].rpc, vecs[k].rwn, vecs[k].rwd);
         trace_en = vecs[k].te;
         #1;
         check($sformatf("v%0d_ref_ready", k), ref_ready, vecs[k].x_ready);
         check($sformatf("v%0d_stall", k), commit_stall, vecs[k].x_stall);
         @(posedge clk);
         #1;
         check($sformatf("v%0d_err", k), err, vecs[k].x_err);
         check($sformatf("v%0d_done", k), done, vecs[k].x_done);
         check($sformatf("v%0d_cc", k), check_count, vecs[k].x_cc);
      end
      trace_en = 1'b1;

      check("rec_lane", err_lane, 1'b0);
      check("rec_pc", err_pc, 32'hbfc00034);
      check("rec_wnum", err_wnum, 5'd8);
      check("rec_wdata", err_wdata, 32'h80);
      check("rec_ref_pc", err_ref_pc, 32'hbfc00034);
      check("rec_ref_wnum", err_ref_wnum, 5'd8);
      check("rec_ref_wdata", err_ref_wdata, 32'h81);
      check("rec_overflow", overflow, 1'b0);

      // Full / overflow: counts 0,2,4,6,7 before each push; stall only at 7
      pulse_reset();
      check("ovf_rst_rec", err_wdata, 32'd0);
      ov_en[0] = 2'b11; ov_en[1] = 2'b11; ov_en[2] = 2'b11; ov_en[3] = 2'b01; ov_en[4] = 2'b11;
      ov_stall[0] = 1'b0; ov_stall[1] = 1'b0; ov_stall[2] = 1'b0; ov_stall[3] = 1'b0; ov_stall[4] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         drive(ov_en[i], 32'hbfc00200 + 32'(i), 5'd10, 32'(i), 32'hbfc00300 + 32'(i), 5'd11, 32'(i), 1'b0, 0, 0, 0);
         #1;
         check($sformatf("ovf_stall%0d", i), commit_stall, ov_stall[i]);
         check($sformatf("ovf_pre_err%0d", i), err, 1'b0);
      end
      @(negedge clk);
      idle();
      #1;
      check("ovf_overflow", overflow, 1'b1);
      check("ovf_err", err, 1'b1);
      check("ovf_count", 32'(dut.count_q), 32'd7);
      check("ovf_stall_err", commit_stall, 1'b0);

      // End PC and mid-queue reset
      pulse_reset();
      check("end_rst_ovf", overflow, 1'b0);
      @(negedge clk);
      drive(2'b11, 32'hbfc00040, 5'd1, 32'ha, 32'hbfc00044, 5'd2, 32'hb, 1'b0, 0, 0, 0);
      @(negedge clk);
      drive(2'b01, 32'hbfc00048, 5'd3, 32'hc, 0, 0, 0, 1'b1, 32'hbfc00040, 5'd1, 32'ha);
      #1;
      check("end_pop_ready", ref_ready, 1'b1);
      @(negedge clk);
      drive(2'b00, 0, 0, 0, 0, 0, 0, 1'b1, END_PC, 5'd0, 32'd0);
      #1;
      check("end_ready", ref_ready, 1'b1);
      check("end_cc_before", check_count, 32'd1);
      @(posedge clk);
      #1;
      check("end_done", done, 1'b1);
      check("end_cc_after", check_count, 32'd1);
      check("end_err", err, 1'b0);
      @(negedge clk);
      drive(2'b00, 0, 0, 0, 0, 0, 0, 1'b1, 32'hbfc00044, 5'd2, 32'hb);
      #1;
      check("done_ready", ref_ready, 1'b0);
      check("done_stall", commit_stall, 1'b0);
      #2 reset = 1'b1;
      #1;
      check("midrst_done", done, 1'b0);
      check("midrst_cc", check_count, 32'd0);
      check("midrst_count", 32'(dut.count_q), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      drive(2'b00, 0, 0, 0, 0, 0, 0, 1'b1, 32'hbfc00044, 5'd2, 32'hb);
      #1;
      check("midrst_empty_ready", ref_ready, 1'b0);

      // Sync: bfc00000 is dropped, bfc00bd4 held then compared
      @(negedge clk);
      idle();
      reset_s = 1'b0;
      @(negedge clk);
      drive(2'b01, 32'hbfc00bd4, 5'd9, 32'h99, 0, 0, 0, 1'b1, 32'hbfc00000, 5'd1, 32'h1);
      #1;
      check("sync_drop_ready", s_ref_ready, 1'b1);
      @(posedge clk);
      #1;
      check("sync_drop_cc", s_check_count, 32'd0);
      @(negedge clk);
      drive(2'b00, 0, 0, 0, 0, 0, 0, 1'b1, 32'hbfc00bd4, 5'd9, 32'h99);
      #1;
      check("sync_hit_ready", s_ref_ready, 1'b0);
      @(negedge clk);
      #1;
      check("sync_run_ready", s_ref_ready, 1'b1);
      @(posedge clk);
      #1;
      check("sync_cc", s_check_count, 32'd1);
      check("sync_err", s_err, 1'b0);
      @(negedge clk);
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
